// File: rtl/count_capture_fifo.sv
// Snapshots a running count into a small FIFO on a capture edge or a periodic tick.
// The management SoC drains the FIFO and manages it over a Wishbone slave port.
module count_capture_fifo #(
  parameter int          BITS     = 32,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0100
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [BITS-1:0] count,
  input  logic            capture_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic            irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            capture_q;
  logic [15:0]     presc, period;
  logic            en, auto_mode;
  logic [3:0]      thresh;
  logic            ovf, unf;

  logic        req, hit, rd_op, wr_op;
  logic [1:0]  off;
  logic        pop, flush, wr_stat, wr_ctrl, wr_period;
  logic        cap_edge, tick, push_req, do_push;
  logic        full, empty, pop_ok, push_ok, set_ovf, set_unf;
  logic [4:0]  level5;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  always_comb begin
    req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    hit       = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    off       = wbs_adr_i[3:2];
    rd_op     = req & hit & ~wbs_we_i;
    wr_op     = req & hit & wbs_we_i;
    pop       = rd_op & (off == 2'd0);
    wr_stat   = wr_op & (off == 2'd1);
    wr_ctrl   = wr_op & (off == 2'd2) & wbs_sel_i[0];
    wr_period = wr_op & (off == 2'd3);
    flush     = wr_ctrl & wbs_dat_i[2];

    full      = (level == LW'(DEPTH));
    empty     = (level == '0);
    level5    = 5'(level);

    cap_edge  = capture_i & ~capture_q;
    tick      = en & auto_mode & (presc == period);
    push_req  = en & (cap_edge | tick);
    do_push   = push_req & ~flush;
    pop_ok    = pop & ~empty;
    // a pop frees the slot, so a full FIFO still accepts the concurrent push
    push_ok   = do_push & (~full | pop_ok);
    set_ovf   = do_push & full & ~pop_ok;
    set_unf   = pop & empty;
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (off)
        2'd0:    if (!empty) rd_val = 32'(mem[rd_ptr]);
        2'd1:    rd_val = {20'd0, unf, ovf, full, empty, 3'd0, level5};
        2'd2:    rd_val = {24'd0, thresh, 2'b00, auto_mode, en};
        default: rd_val = {16'd0, period};
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= count;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      capture_q <= 1'b0;
      presc     <= '0;
      period    <= '0;
      en        <= 1'b0;
      auto_mode <= 1'b0;
      thresh    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd_op ? rd_val : 32'd0;
      capture_q <= capture_i;
      irq_o     <= ((thresh != 4'd0) && (level5 >= {1'b0, thresh})) | ovf;

      if (wr_period || !(en && auto_mode) || tick) presc <= '0;
      else presc <= presc + 16'd1;

      if (wr_period && wbs_sel_i[0]) period[7:0]  <= wbs_dat_i[7:0];
      if (wr_period && wbs_sel_i[1]) period[15:8] <= wbs_dat_i[15:8];

      if (wr_ctrl) begin
        en        <= wbs_dat_i[0];
        auto_mode <= wbs_dat_i[1];
        thresh    <= wbs_dat_i[7:4];
      end

      // a set event in the same cycle as a W1C wins
      ovf <= set_ovf | (ovf & ~(wr_stat & wbs_dat_i[10]));
      unf <= set_unf | (unf & ~(wr_stat & wbs_dat_i[11]));

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop_ok)      level <= level + LW'(1);
        else if (pop_ok && !push_ok) level <= level - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Self-checking bench for count_capture_fifo: register vector table plus
// hand-written capture, overflow, concurrency, threshold, flush and reset sequences.
module tb_count_capture_fifo;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] BASE   = 32'h3000_0100;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_PER  = BASE + 32'hC;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] count;
  logic        capture_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        irq_o;

  logic        free_run;
  logic [31:0] man_cnt;
  logic [31:0] fr_cnt = '0;

  count_capture_fifo #(.BITS(32), .DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .count    (count),
    .capture_i(capture_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .irq_o    (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) fr_cnt <= fr_cnt + 32'd1;
  assign count = free_run ? fr_cnt : man_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[$];
  logic        m_ovf, m_unf;
  logic [31:0] last_ack_cyc;
  logic [31:0] cyc_a;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {20'd0, m_unf, m_ovf, (model.size() == DEPTH), (model.size() == 0), 3'd0,
            5'(model.size())};
  endfunction

  function automatic logic [31:0] m_data();
    if (model.size() == 0) begin
      m_unf = 1'b1;
      return 32'd0;
    end
    return model.pop_front();
  endfunction

  task automatic m_push(input logic [31:0] v);
    if (model.size() < DEPTH) model.push_back(v);
    else m_ovf = 1'b1;
  endtask

  task automatic bus_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    if (!we) exp_q.push_back(exp);
  endtask

  task automatic bus_finish(input string name);
    logic        got;
    logic [31:0] e;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    check({name, " ack"}, 32'(got), 32'd1);
    last_ack_cyc = fr_cnt;
    if (!wbs_we_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got) check(name, wbs_dat_o, e);
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp, input string name);
    bus_start(we, adr, dat, sel, exp);
    bus_finish(name);
    @(posedge wb_clk_i); #1;
    check({name, " ack drop"}, 32'(wbs_ack_o), 32'd0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
    xfer(1'b0, adr, 32'd0, 4'hF, exp, name);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string name);
    xfer(1'b1, adr, dat, 4'hF, 32'd0, name);
  endtask

  task automatic pulse(input logic [31:0] v);
    man_cnt   = v;
    capture_i = 1'b1;
    m_push(v);
    @(posedge wb_clk_i); #1;
    capture_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i  = 1'b1;
    capture_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    free_run  = 1'b0;
    man_cnt   = '0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;

    vt.push_back('{1'b0, A_STAT, 32'h0,          4'hF, 32'h100});
    vt.push_back('{1'b0, A_CTRL, 32'h0,          4'hF, 32'h0});
    vt.push_back('{1'b0, A_PER,  32'h0,          4'hF, 32'h0});
    vt.push_back('{1'b1, A_PER,  32'hABCD_1234,  4'hF, 32'h0});
    vt.push_back('{1'b0, A_PER,  32'h0,          4'hF, 32'h1234});
    vt.push_back('{1'b1, A_PER,  32'hFFFF_FF56,  4'h1, 32'h0});
    vt.push_back('{1'b0, A_PER,  32'h0,          4'hF, 32'h1256});
    vt.push_back('{1'b1, A_CTRL, 32'hFFFF_FFF6,  4'h1, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0,          4'hF, 32'hF2});
    vt.push_back('{1'b1, A_CTRL, 32'h31,         4'hE, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0,          4'hF, 32'hF2});
    vt.push_back('{1'b1, A_CTRL, 32'h0,          4'hF, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0,          4'hF, 32'h0});
    vt.push_back('{1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vt.push_back('{1'b0, BASE + 32'h10, 32'h0,   4'hF, 32'h0});
    vt.push_back('{1'b0, 32'h3000_0000, 32'h0,   4'hF, 32'h0});
    vt.push_back('{1'b1, A_DATA, 32'h1234,       4'hF, 32'h0});
    vt.push_back('{1'b0, A_STAT, 32'h0,          4'hF, 32'h100});
    vt.push_back('{1'b1, A_STAT, 32'hFFFF_FFFF,  4'hF, 32'h0});
    vt.push_back('{1'b0, A_STAT, 32'h0,          4'hF, 32'h100});
    vt.push_back('{1'b1, A_PER,  32'h0,          4'hF, 32'h0});
    vt.push_back('{1'b0, A_PER,  32'h0,          4'hF, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0,          4'hF, 32'h0});

    repeat (2) @(posedge wb_clk_i);
    #1;
    check("reset ack", 32'(wbs_ack_o), 32'd0);
    check("reset dat", wbs_dat_o, 32'd0);
    check("reset irq", 32'(irq_o), 32'd0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    for (int i = 0; i < vt.size(); i++)
      xfer(vt[i].we, vt[i].adr, vt[i].wdat, vt[i].sel, vt[i].exp, $sformatf("vec%0d", i));

    // edge capture
    wr(A_CTRL, 32'h1, "edge en");
    pulse(32'd5);
    pulse(32'd9);
    rd(A_STAT, m_status(), "edge level");
    rd(A_DATA, m_data(), "edge data0");
    rd(A_DATA, m_data(), "edge data1");
    rd(A_DATA, m_data(), "edge underflow data");
    rd(A_STAT, m_status(), "edge underflow status");
    check("edge underflow model", m_status(), 32'h900);
    wr(A_STAT, 32'h800, "edge w1c");
    m_unf = 1'b0;
    rd(A_STAT, m_status(), "edge w1c status");

    // periodic capture
    wr(A_PER, 32'd3, "per period");
    free_run = 1'b1;
    wr(A_CTRL, 32'h3, "per auto on");
    cyc_a = last_ack_cyc;
    repeat (10) @(posedge wb_clk_i);
    #1;
    wr(A_CTRL, 32'h1, "per auto off");
    free_run = 1'b0;
    m_push(cyc_a + 32'd3);
    m_push(cyc_a + 32'd7);
    m_push(cyc_a + 32'd11);
    rd(A_STAT, m_status(), "per level");
    for (int i = 0; i < 3; i++) rd(A_DATA, m_data(), $sformatf("per data%0d", i));

    // overflow
    for (int i = 0; i < 9; i++) pulse(32'd100 + 32'(i));
    check("ovf irq", 32'(irq_o), 32'd1);
    rd(A_STAT, m_status(), "ovf status");
    wr(A_STAT, 32'h400, "ovf w1c");
    m_ovf = 1'b0;
    check("ovf irq clear", 32'(irq_o), 32'd0);
    rd(A_STAT, m_status(), "ovf status clear");

    // pop coinciding with a push on a full FIFO
    bus_start(1'b0, A_DATA, 32'd0, 4'hF, m_data());
    man_cnt   = 32'd200;
    capture_i = 1'b1;
    m_push(32'd200);
    bus_finish("pp data");
    capture_i = 1'b0;
    @(posedge wb_clk_i); #1;
    rd(A_STAT, m_status(), "pp status");
    for (int i = 0; i < DEPTH; i++) rd(A_DATA, m_data(), $sformatf("pp drain%0d", i));
    rd(A_STAT, m_status(), "pp empty");

    // threshold interrupt
    wr(A_CTRL, 32'h31, "thr ctrl");
    pulse(32'd300);
    pulse(32'd301);
    check("thr irq below", 32'(irq_o), 32'd0);
    man_cnt   = 32'd302;
    capture_i = 1'b1;
    m_push(32'd302);
    @(posedge wb_clk_i); #1;
    check("thr irq n+1", 32'(irq_o), 32'd0);
    capture_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("thr irq n+2", 32'(irq_o), 32'd1);
    bus_start(1'b0, A_DATA, 32'd0, 4'hF, m_data());
    bus_finish("thr pop");
    check("thr irq at ack", 32'(irq_o), 32'd1);
    @(posedge wb_clk_i); #1;
    check("thr irq drop", 32'(irq_o), 32'd0);

    // flush, then reset during a pending request
    pulse(32'd400);
    pulse(32'd401);
    pulse(32'd402);
    rd(A_STAT, m_status(), "fl level5");
    wr(A_PER, 32'h55, "fl period");
    wr(A_CTRL, 32'h5, "fl flush");
    model.delete();
    rd(A_STAT, m_status(), "fl status");
    rd(A_CTRL, 32'h1, "fl ctrl");
    pulse(32'd500);
    rd(A_STAT, m_status(), "fl refill");

    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = A_STAT;
    wb_rst_i  = 1'b1;
    @(posedge wb_clk_i); #1;
    check("rst ack", 32'(wbs_ack_o), 32'd0);
    check("rst dat", wbs_dat_o, 32'd0);
    wb_rst_i  = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    model.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst ack idle", 32'(wbs_ack_o), 32'd0);
    rd(A_STAT, m_status(), "rst status");
    rd(A_CTRL, 32'h0, "rst ctrl");
    rd(A_PER, 32'h0, "rst period");
    check("rst irq", 32'(irq_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Downstream consumer of the counter's `count` output inside the user project. It snapshots the running count into a DEPTH-entry FIFO, either on a rising edge of a trigger line or periodically from an internal prescaler. The management SoC drains the snapshots over a Wishbone slave port. An interrupt fires when the fill level reaches a programmable threshold or when a sample is lost.

## Interface
- `BITS`, 32: width of the `count` input; zero-extended to 32 bits on read (BITS ≤ 32).
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `BASE_ADR`, 32'h3000_0100: Wishbone base; decode matches `wbs_adr_i[31:4] == BASE_ADR[31:4]`.

Ports:
- `wb_clk_i`  in  1  the single clock; all state updates on its rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `count`  in  BITS  live counter value to snapshot.
- `capture_i`  in  1  trigger level; a 0→1 edge requests one capture.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone strobe, cycle, write enable.
- `wbs_sel_i`  in  4  byte lanes; honoured on CTRL/PERIOD writes.
- `wbs_adr_i`  in  32  byte address; offset is `adr[3:2]`.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid while `wbs_ack_o` = 1.
- `irq_o`  out  1  registered interrupt level.

## Operation
Registers (offset from BASE_ADR):
- **0x0 DATA (R).** Returns the FIFO head and pops one entry. If the FIFO is empty, returns 0 and sets UNDERFLOW. Writes are ignored.
- **0x4 STATUS.** Read fields:
  - [4:0] level
  - [8] empty
  - [9] full
  - [10] OVERFLOW sticky
  - [11] UNDERFLOW sticky
  
  Writing 1 to bit 10 or bit 11 clears that bit (W1C). All other bits read 0.
- **0x8 CTRL (RW).** Fields:
  - [0] EN
  - [1] AUTO
  - [2] FLUSH: write-1 pulse; always reads 0
  - [7:4] THRESH
- **0xC PERIOD (RW).** [15:0] prescale value; [31:16] read 0.

Capture:
- Edge detect: `capture_q` is `capture_i` registered. `edge = capture_i & ~capture_q`.
- Periodic tick (AUTO = 1): a 16-bit prescaler counts 0..PERIOD, then wraps to 0.
  - A tick is raised in the wrap cycle.
  - PERIOD = 0 gives a tick every cycle.
  - The prescaler is held at 0 while EN = 0 or AUTO = 0.
  - Writing PERIOD resets the prescaler to 0.
- Push request: `EN & (edge | tick)`. At most one push per cycle; an edge and a tick in the same cycle yield one push.
- The value pushed is `count` as sampled in the request cycle.

FIFO:
- Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Level is 0..DEPTH.
- Push when full with no pop in the same cycle: the sample is dropped, OVERFLOW is set, and FIFO contents are unchanged.
- Push and pop in the same cycle: both take effect and the level is unchanged. This includes the full case, where no overflow occurs.
- Pop when empty with a simultaneous push: the read returns 0, UNDERFLOW is set, and the push is stored. There is no bypass.
- FLUSH: pointers and level go to 0 in the ack cycle. Sticky bits are not cleared. A push in that same cycle is discarded.
- Simultaneous W1C clear and a new set event on the same sticky bit: the set wins.

Wishbone:
- `req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o`.
- `wbs_ack_o` is registered and asserted the cycle after `req`, for exactly one cycle.
- The register side effect (pop, write, W1C, flush) occurs once, in the ack cycle.
- An address outside the 16-byte window, or an unused field, still acks and reads 0. Writes there are ignored.

IRQ:
- `irq_o` is registered: `(THRESH != 0 & level >= THRESH) | OVERFLOW`.

## Timing
- Reset values: all registers, pointers, prescaler, `capture_q`, `wbs_ack_o`, `wbs_dat_o` and `irq_o` are 0; the FIFO is empty.
- Reset asserted mid-transaction: the ack is suppressed and all state returns to reset values on the next edge.
- Capture latency: a request in cycle N is visible in STATUS.level in cycle N+1, and in `irq_o` in cycle N+2.
- Read latency: `wbs_dat_o` and `wbs_ack_o` are valid in cycle N+1 for a request in cycle N. Back-to-back reads complete every 2 cycles.
- The DATA value returned is the head before the pop.

## Test plan
- **Edge capture:** EN = 1, `count` = 5 with one `capture_i` pulse, then `count` = 9 with another pulse → STATUS.level = 2; DATA reads return 5, then 9, then 0 with UNDERFLOW (STATUS = 0x900). The value 0x900 is UNDERFLOW plus empty.
- **Periodic capture:** PERIOD = 3, AUTO = 1, EN = 1, run 12 cycles → exactly 3 pushes, 4 cycles apart, with consecutive captured counts differing by 4 when the counter is free-running.
- **Overflow:** DEPTH = 8, issue 9 edges with no reads → level = 8, full = 1, OVERFLOW = 1, `irq_o` = 1, and the oldest entry is the first count. Write STATUS = 0x400 → OVERFLOW = 0.
- **Push/pop concurrency:** with the FIFO full, a DATA read ack coincides with a capture → level stays 8, OVERFLOW stays 0, and the new sample becomes the tail.
- **Threshold IRQ:** THRESH = 3; after the 3rd capture, `irq_o` rises 2 cycles after the request. One DATA read drops it the cycle after the level falls to 2.
- **Flush and reset:** with 5 entries, write CTRL = 0x5 → level = 0 and EN stays 1. Assert `wb_rst_i` for 1 cycle during a pending `req` → no ack, and all registers read 0.
